stat_bist_sequencer: RTL and testbench

//   Built-in self-test sequencer for the generated combinational Stat benchmark cores (31 in / 17 out).
//   - Drives the core's inputs from an LFSR pattern generator.
//   - Waits for the core outputs to settle, then compacts them into a MISR.
//   - After N patterns, reports the signature and a pass/fail result against a golden value.
//   The core under test is instantiated beside this block and is fully combinational.

---
 rtl/stat_bist_sequencer.sv | 147 ++++++++++++++
 tb/tb_stat_bist_sequencer.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/stat_bist_sequencer.sv
// BIST sequencer for combinational Stat cores: LFSR stimulus, MISR compaction,
// signature/pass reporting against a golden value.
module stat_bist_sequencer #(
  parameter int N_IN   = 31,
  parameter int N_OUT  = 17,
  parameter int CNT_W  = 16,
  parameter int SETTLE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] num_patterns,
  input  logic [N_IN-1:0]  seed,
  input  logic [N_OUT-1:0] golden,
  output logic [N_IN-1:0]  cut_in,
  input  logic [N_OUT-1:0] cut_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [N_OUT-1:0] signature
);

  localparam int ST_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_APPLY,
    S_CAPTURE,
    S_FINISH
  } state_t;

  state_t           r_state;
  state_t           w_nxt;
  logic [CNT_W-1:0] r_num;
  logic [CNT_W-1:0] r_cnt;
  logic [N_OUT-1:0] r_golden;
  logic [N_OUT-1:0] r_misr;
  logic [N_OUT-1:0] r_sig;
  logic [N_IN-1:0]  r_lfsr;
  logic [N_IN-1:0]  r_cut_in;
  logic [ST_W-1:0]  r_settle;
  logic             r_pass;

  logic [N_IN-1:0]  w_seed;
  logic [N_IN-1:0]  w_lfsr_nxt;
  logic [N_OUT-1:0] w_misr_nxt;
  logic             w_settled;
  logic             w_last;
  logic             w_empty;

  // A zero seed would lock the LFSR, so substitute all-ones.
  assign w_seed     = (seed == '0) ? '1 : seed;
  assign w_lfsr_nxt = {r_lfsr[N_IN-2:0],
                       r_lfsr[N_IN-1] ^ r_lfsr[N_IN-4]};
  assign w_misr_nxt = {r_misr[N_OUT-2:0],
                       r_misr[N_OUT-1] ^ r_misr[N_OUT-4]}
                      ^ cut_out;
  assign w_settled  = (r_settle == ST_W'(SETTLE - 1));
  assign w_last     = (r_cnt == r_num - CNT_W'(1));
  assign w_empty    = (num_patterns == '0);

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_nxt;
  end

  always_comb begin
    w_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (start) w_nxt = w_empty ? S_FINISH : S_APPLY;
      end
      S_APPLY: begin
        if (abort)          w_nxt = S_IDLE;
        else if (w_settled) w_nxt = S_CAPTURE;
      end
      S_CAPTURE: begin
        if (abort)       w_nxt = S_IDLE;
        else if (w_last) w_nxt = S_FINISH;
        else             w_nxt = S_APPLY;
      end
      S_FINISH: w_nxt = S_IDLE;
      default:  w_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_num    <= '0;
      r_cnt    <= '0;
      r_golden <= '0;
      r_misr   <= '0;
      r_sig    <= '0;
      r_lfsr   <= '0;
      r_cut_in <= '0;
      r_settle <= '0;
      r_pass   <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_num    <= num_patterns;
            r_golden <= golden;
            r_lfsr   <= w_seed;
            r_cut_in <= w_empty ? '0 : w_seed;
            r_misr   <= '0;
            r_cnt    <= '0;
            r_settle <= '0;
            r_sig    <= '0;
            r_pass   <= w_empty && (golden == '0);
          end
        end
        S_APPLY: begin
          if (abort)           r_cut_in <= '0;
          else if (!w_settled) r_settle <= r_settle + ST_W'(1);
        end
        S_CAPTURE: begin
          if (abort) begin
            r_cut_in <= '0;
          end else begin
            r_misr   <= w_misr_nxt;
            r_lfsr   <= w_lfsr_nxt;
            r_cnt    <= r_cnt + CNT_W'(1);
            r_settle <= '0;
            // Publish the result as FINISH is entered so it is valid with done.
            if (w_last) begin
              r_sig  <= w_misr_nxt;
              r_pass <= (w_misr_nxt == r_golden);
            end else begin
              r_cut_in <= w_lfsr_nxt;
            end
          end
        end
        S_FINISH: r_cut_in <= '0;
        default:  r_cut_in <= '0;
      endcase
    end
  end

  assign cut_in    = r_cut_in;
  assign busy      = (r_state == S_APPLY) || (r_state == S_CAPTURE);
  assign done      = (r_state == S_FINISH);
  assign pass      = r_pass;
  assign signature = r_sig;

endmodule

// File: tb/tb_stat_bist_sequencer.sv
// Directed bench for stat_bist_sequencer with a small LFSR/MISR reference model
// and a stand-in combinational core.
module tb_stat_bist_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        abort;
  logic [15:0] num_patterns;
  logic [30:0] seed;
  logic [16:0] golden;
  logic [30:0] cut_in;
  logic [16:0] cut_out;
  logic        busy;
  logic        done;
  logic        pass;
  logic [16:0] signature;

  int n_chk  = 0;
  int n_fail = 0;
  int mode   = 0;

  always #5 clk = ~clk;

  stat_bist_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .abort        (abort),
    .num_patterns (num_patterns),
    .seed         (seed),
    .golden       (golden),
    .cut_in       (cut_in),
    .cut_out      (cut_out),
    .busy         (busy),
    .done         (done),
    .pass         (pass),
    .signature    (signature)
  );

  function automatic logic [16:0] core(int m, logic [30:0] x);
    logic [16:0] y;
    case (m)
      0:       y = 17'h1ABCD;
      1:       y = (x == 31'h1) ? 17'h1ABCD : 17'h0;
      default: y = x[16:0] ^ x[30:14] ^ {x[7:0], x[30:22]};
    endcase
    return y;
  endfunction

  always_comb cut_out = core(mode, cut_in);

  function automatic logic [16:0] model(int m, logic [30:0] s, int n);
    logic [30:0] l;
    logic [16:0] g;
    l = (s == '0) ? '1 : s;
    g = '0;
    for (int i = 0; i < n; i++) begin
      g = {g[15:0], g[16] ^ g[13]} ^ core(m, l);
      l = {l[29:0], l[30] ^ l[27]};
    end
    return g;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic kick(logic [30:0] s, int n, logic [16:0] g);
    seed         = s;
    num_patterns = 16'(n);
    golden       = g;
    start        = 1'b1;
    tick();
    start        = 1'b0;
  endtask

  // Runs from start to done; cyc is the cycle done was seen (start = cycle 0).
  task automatic run(logic [30:0] s, int n, logic [16:0] g,
                     bit bump, output int cyc);
    kick(s, n, g);
    cyc = 1;
    if (bump) begin
      seed  = ~s;
      start = 1'b1;
      tick();
      start = 1'b0;
      cyc++;
    end
    while (!done && cyc < 2 * n + 20) begin
      tick();
      cyc++;
    end
    if (!done) chk("done_timeout", 0, 1);
  endtask

  initial begin
    int cyc;
    int dcnt;
    int n;
    logic [30:0] s;
    logic [16:0] exp_sig;
    logic [16:0] sig_a;

    rst = 1'b1; start = 1'b0; abort = 1'b0;
    num_patterns = '0; seed = '0; golden = '0;
    repeat (3) tick();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_cut_in", 32'(cut_in), 0);
    chk("rst_sig", 32'(signature), 0);
    chk("rst_pass", 32'(pass), 0);
    rst = 1'b0;
    tick();

    // Single pattern, constant core output matching golden
    mode = 0;
    kick(31'h1, 1, 17'h1ABCD);
    chk("t2_cut_in_c1", 32'(cut_in), 32'h1);
    chk("t2_busy_c1", 32'(busy), 1);
    tick();
    chk("t2_done_c2", 32'(done), 0);
    tick();
    chk("t2_done_c3", 32'(done), 1);
    chk("t2_sig", 32'(signature), 32'h1ABCD);
    chk("t2_pass", 32'(pass), 1);
    tick();
    chk("t2_done_c4", 32'(done), 0);
    chk("t2_sig_hold", 32'(signature), 32'h1ABCD);

    // Two patterns, response depends on pattern
    mode = 1;
    kick(31'h1, 2, 17'h0);
    chk("t3_cut_in_c1", 32'(cut_in), 32'h1);
    chk("t3_sig_clr", 32'(signature), 0);
    tick(); tick();
    chk("t3_cut_in_c3", 32'(cut_in), 32'h2);
    tick();
    chk("t3_done_c4", 32'(done), 0);
    tick();
    chk("t3_done_c5", 32'(done), 1);
    chk("t3_sig", 32'(signature), 32'h1579A);
    chk("t3_pass", 32'(pass), 0);
    tick();

    // Zero seed and zero-length run
    mode = 0;
    kick(31'h0, 1, 17'h0);
    chk("t4_seed0", 32'(cut_in), 32'h7FFFFFFF);
    tick(); tick(); tick();
    kick(31'h5, 0, 17'h0);
    chk("t4_n0_done", 32'(done), 1);
    chk("t4_n0_sig", 32'(signature), 0);
    chk("t4_n0_pass", 32'(pass), 1);
    chk("t4_n0_busy", 32'(busy), 0);
    tick();

    // Reset in cycle 2 of a run
    mode = 2;
    kick(31'h1234, 4, 17'h0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t1_busy", 32'(busy), 0);
    chk("t1_done", 32'(done), 0);
    chk("t1_cut_in", 32'(cut_in), 0);
    chk("t1_sig", 32'(signature), 0);
    tick();

    // Abort in cycle 2
    kick(31'h55AA, 4, 17'h0);
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t5_abort_busy", 32'(busy), 0);
    chk("t5_abort_cut_in", 32'(cut_in), 0);
    dcnt = 0;
    for (int i = 0; i < 12; i++) begin
      if (done) dcnt++;
      tick();
    end
    chk("t5_no_done", 32'(dcnt), 0);
    chk("t5_abort_sig", 32'(signature), 0);
    chk("t5_abort_pass", 32'(pass), 0);

    // start while busy is ignored; a rerun reproduces the signature
    exp_sig = model(2, 31'h3C3C3C3, 3);
    run(31'h3C3C3C3, 3, exp_sig, 1'b1, cyc);
    chk("t5_bump_lat", 32'(cyc), 7);
    chk("t5_bump_sig", 32'(signature), 32'(exp_sig));
    chk("t5_bump_pass", 32'(pass), 1);
    sig_a = signature;
    tick();
    run(31'h3C3C3C3, 3, 17'h0, 1'b0, cyc);
    chk("t5_rerun_sig", 32'(signature), 32'(sig_a));
    tick();

    // Random seeds and lengths against the model
    for (int r = 0; r < 6; r++) begin
      s = 31'($urandom);
      n = (r == 0) ? 500 : int'($urandom_range(1, 500));
      exp_sig = model(2, s, n);
      run(s, n, (r % 2 == 1) ? exp_sig : ~exp_sig, 1'b0, cyc);
      chk("t6_lat", 32'(cyc), 32'(1 + 2 * n));
      chk("t6_sig", 32'(signature), 32'(exp_sig));
      chk("t6_pass", 32'(pass), 32'(r % 2 == 1));
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
